prod_accumulator: RTL and testbench

- Sequential stage directly downstream of the 4x4 array multiplier.
- Consumes the 8-bit products over a valid/ready handshake.
- Sums N_TERMS consecutive products into one dot-product result.
- Presents that result on a registered valid/ready output port.
- Turns the purely combinational multiplier into a multiply-accumulate datapath for filter and dot-product use.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/prod_accumulator.sv | 115 +++++++++++
 tb/tb_prod_accumulator.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath.
package mac_pkg;

  // Product width produced by the 4x4 array multiplier.
  localparam int PROD_W = 8;

  // Accumulator control state.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/prod_accumulator.sv
// Sums N_TERMS consecutive multiplier products and presents the total on a
// registered valid/ready port. A new sum may start in the same beat that the
// previous result drains.
module prod_accumulator
  import mac_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              busy
);

  localparam int CNT_W = (clog2(N_TERMS) < 1) ? 1 : clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  // Reject parameterisations that could overflow or make no sense.
  if (N_TERMS < 2 || N_TERMS > 16) begin : g_bad_n_terms
    $error("prod_accumulator: N_TERMS must be in 2..16");
  end
  if (ACC_W < PROD_W + clog2(N_TERMS)) begin : g_bad_acc_w
    $error("prod_accumulator: ACC_W too narrow for N_TERMS products");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W-1:0] out_sum_nxt;
  logic             out_valid_nxt;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] sum;
  logic             accept;
  logic             drain;

  // Input is open while collecting, or when the held result drains this beat.
  assign in_ready = (state == ACCUM) || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign busy     = (count != '0);
  assign p_ext    = ACC_W'(in_p);
  assign sum      = acc + p_ext;

  // Next-state and datapath update; clr overrides any accept.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    acc_nxt       = acc;
    out_sum_nxt   = out_sum;
    out_valid_nxt = out_valid;
    if (clr) begin
      state_nxt     = ACCUM;
      count_nxt     = '0;
      acc_nxt       = '0;
      out_valid_nxt = 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (count == LAST) begin
              out_sum_nxt   = sum;
              out_valid_nxt = 1'b1;
              count_nxt     = '0;
              state_nxt     = HOLD;
            end else begin
              acc_nxt   = (count == '0) ? p_ext : sum;
              count_nxt = count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (drain) begin
            out_valid_nxt = 1'b0;
            state_nxt     = ACCUM;
            // Accept here starts a fresh sum; N_TERMS >= 2 so it cannot complete.
            if (accept) begin
              acc_nxt   = p_ext;
              count_nxt = CNT_W'(1);
            end
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Counter, partial sum and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      acc       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else begin
      count     <= count_nxt;
      acc       <= acc_nxt;
      out_sum   <= out_sum_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator with N_TERMS=4, ACC_W=10.
module tb_prod_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_p;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_sum;
  logic       busy;

  int vecs = 0;
  int errs = 0;

  prod_accumulator #(.N_TERMS(4), .ACC_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] p);
    in_valid = 1'b1;
    in_p     = p;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_p = '0; out_ready = 1'b0;
    repeat (3) cyc();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++; if (out_sum !== 10'd0) begin errs++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic_sum();
    out_ready = 1'b1;
    beat(8'd10);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy got %b want 1", busy); end
    beat(8'd20);
    beat(8'd30);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    beat(8'd40);
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %b want 1", out_valid); end
    vecs++; if (out_sum !== 10'd100) begin errs++; $display("FAIL basic_sum got %0d want 100", out_sum); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_done got %b want 0", busy); end
    cyc();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_drain got %b want 0", out_valid); end
  endtask

  task automatic test_max_values();
    out_ready = 1'b1;
    repeat (4) beat(8'd225);
    vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd900) begin errs++; $display("FAIL max_225 got v=%b sum=%0d want v=1 sum=900", out_valid, out_sum); end
    cyc();
    repeat (4) beat(8'd255);
    vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd1020) begin errs++; $display("FAIL max_255 got v=%b sum=%0d want v=1 sum=1020", out_valid, out_sum); end
    cyc();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL max_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(8'd1); beat(8'd2); beat(8'd3); beat(8'd4);
    vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd10) begin errs++; $display("FAIL bp_result got v=%b sum=%0d want v=1 sum=10", out_valid, out_sum); end
    in_valid = 1'b1; in_p = 8'd99;
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      cyc();
      vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd10 || busy !== 1'b0) begin errs++; $display("FAIL bp_hold[%0d] got v=%b sum=%0d busy=%b want v=1 sum=10 busy=0", i, out_valid, out_sum, busy); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    vecs++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL bp_drain got v=%b busy=%b want v=0 busy=0", out_valid, busy); end
  endtask

  task automatic test_drain_accept();
    out_ready = 1'b0;
    beat(8'd1); beat(8'd2); beat(8'd3); beat(8'd4);
    vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd10) begin errs++; $display("FAIL da_hold got v=%b sum=%0d want v=1 sum=10", out_valid, out_sum); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_p = 8'd7;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL da_in_ready got %b want 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b0 || busy !== 1'b1 || out_sum !== 10'd10) begin errs++; $display("FAIL da_beat got v=%b busy=%b sum=%0d want v=0 busy=1 sum=10", out_valid, busy, out_sum); end
    beat(8'd8); beat(8'd9); beat(8'd11);
    vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd35) begin errs++; $display("FAIL da_next_sum got v=%b sum=%0d want v=1 sum=35", out_valid, out_sum); end
    cyc();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    beat(8'd1); beat(8'd2); beat(8'd3); beat(8'd4);
    vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd10) begin errs++; $display("FAIL b2b_first got v=%b sum=%0d want v=1 sum=10", out_valid, out_sum); end
    beat(8'd5); beat(8'd6); beat(8'd7); beat(8'd8);
    vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd26) begin errs++; $display("FAIL b2b_second got v=%b sum=%0d want v=1 sum=26", out_valid, out_sum); end
    cyc();
  endtask

  task automatic test_clr();
    out_ready = 1'b1;
    beat(8'd50); beat(8'd60);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL clr_busy_before got %b want 1", busy); end
    clr = 1'b1; in_valid = 1'b1; in_p = 8'd200;
    cyc();
    clr = 1'b0; in_valid = 1'b0;
    vecs++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errs++; $display("FAIL clr_abort got busy=%b v=%b want busy=0 v=0", busy, out_valid); end
    beat(8'd1); beat(8'd1); beat(8'd1); beat(8'd1);
    vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd4) begin errs++; $display("FAIL clr_sum got v=%b sum=%0d want v=1 sum=4", out_valid, out_sum); end
    cyc();
    out_ready = 1'b0;
    beat(8'd2); beat(8'd2); beat(8'd2); beat(8'd2);
    vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd8) begin errs++; $display("FAIL clr_hold_sum got v=%b sum=%0d want v=1 sum=8", out_valid, out_sum); end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    vecs++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 10'd8) begin errs++; $display("FAIL clr_in_hold got v=%b busy=%b sum=%0d want v=0 busy=0 sum=8", out_valid, busy, out_sum); end
    repeat (2) cyc();
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL clr_stay_idle got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    out_ready = 1'b1;
    beat(8'd3); beat(8'd3); beat(8'd3); beat(8'd3);
    vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd12) begin errs++; $display("FAIL clr_after_sum got v=%b sum=%0d want v=1 sum=12", out_valid, out_sum); end
    cyc();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    beat(8'd5); beat(8'd5);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL ar_busy_before got %b want 1", busy); end
    #3;
    rst_n = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 10'd0) begin errs++; $display("FAIL ar_immediate got v=%b busy=%b sum=%0d want v=0 busy=0 sum=0", out_valid, busy, out_sum); end
    cyc();
    rst_n = 1'b1;
    cyc();
    beat(8'd5); beat(8'd5); beat(8'd5);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL ar_no_early got %b want 0", out_valid); end
    beat(8'd5);
    vecs++; if (out_valid !== 1'b1 || out_sum !== 10'd20) begin errs++; $display("FAIL ar_sum got v=%b sum=%0d want v=1 sum=20", out_valid, out_sum); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_max_values();
    test_backpressure();
    test_drain_accept();
    test_back_to_back();
    test_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
